// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock / countdown timer slice.
// Provides cd_state_t, default field limits and the preset clamp.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  localparam int HOUR_MAX_D = 23;
  localparam int MS_MAX_D   = 59;

  function automatic int unsigned clamp(
    input int unsigned val,
    input int unsigned max
  );
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/cd_field.sv
// One time field: mod-(MAX+1) down counter with load and borrow chain.
// Ports: clk_i, rst_n_i, load_i, load_val_i, dec_en_i, val_o, is_zero_o, borrow_o.
module cd_field #(
  parameter int W   = 8,
  parameter int MAX = 59
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_en_i,
  output logic [W-1:0] val_o,
  output logic         is_zero_o,
  output logic         borrow_o
);

  logic [W-1:0] val_q, val_d;

  assign is_zero_o = (val_q == '0);
  // Wrapping from 0 to MAX asks the next field up for a borrow.
  assign borrow_o  = dec_en_i & is_zero_o;
  assign val_o     = val_q;

  always_comb begin
    val_d = val_q;
    if (load_i)
      val_d = load_val_i;
    else if (dec_en_i)
      val_d = is_zero_o ? W'(MAX) : val_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) val_q <= '0;
    else          val_q <= val_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS down-counting timer with load, pause and expiry flag.
// Ports: clock_1HZ, reset (async low), load, run, pre_h/m/s -> hour, minute,
// second, running, expired. Optional COUNTDOWN_REPEAT_EN: auto-reload mode.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int W        = 8,
  parameter int HOUR_MAX = HOUR_MAX_D,
  parameter int MS_MAX   = MS_MAX_D
) (
  input  logic         clock_1HZ,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] pre_h,
  input  logic [W-1:0] pre_m,
  input  logic [W-1:0] pre_s,
  output logic [W-1:0] hour,
  output logic [W-1:0] minute,
  output logic [W-1:0] second,
  output logic         running,
  output logic         expired
);

  cd_state_t state_q, state_d;
  logic      exp_q, exp_d;
  logic      dec, reload, fld_load;
  logic      s_zero, m_zero, h_zero, cnt_zero, at_one;
  logic      s_borrow, m_borrow, h_borrow_unused;
  logic [W-1:0] pc_h, pc_m, pc_s;
  logic [W-1:0] ld_h, ld_m, ld_s;

  assign pc_h = W'(clamp(32'(pre_h), HOUR_MAX));
  assign pc_m = W'(clamp(32'(pre_m), MS_MAX));
  assign pc_s = W'(clamp(32'(pre_s), MS_MAX));

`ifdef COUNTDOWN_REPEAT_EN
  logic [W-1:0] sh_h_q, sh_m_q, sh_s_q;

  always_ff @(posedge clock_1HZ or negedge reset) begin
    if (!reset) begin
      sh_h_q <= '0;
      sh_m_q <= '0;
      sh_s_q <= '0;
    end else if (load) begin
      sh_h_q <= pc_h;
      sh_m_q <= pc_m;
      sh_s_q <= pc_s;
    end
  end

  assign ld_h = load ? pc_h : sh_h_q;
  assign ld_m = load ? pc_m : sh_m_q;
  assign ld_s = load ? pc_s : sh_s_q;
`else
  assign ld_h = pc_h;
  assign ld_m = pc_m;
  assign ld_s = pc_s;
`endif

  assign fld_load = load | reload;
  assign cnt_zero = s_zero & m_zero & h_zero;
  // One second left: the next decrement lands on 00:00:00.
  assign at_one   = h_zero & m_zero & (second == W'(1));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    dec     = 1'b0;
    reload  = 1'b0;
    if (load) begin
      state_d = IDLE;
      exp_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (run) begin
            if (cnt_zero) begin
              state_d = DONE;
              exp_d   = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
`ifdef COUNTDOWN_REPEAT_EN
          // Expiry is a single-edge pulse in repeat mode.
          exp_d = 1'b0;
          if (!run) begin
            state_d = PAUSE;
          end else if (cnt_zero) begin
            reload = 1'b1;
          end else begin
            dec = 1'b1;
            if (at_one) exp_d = 1'b1;
          end
`else
          if (!run) begin
            state_d = PAUSE;
          end else begin
            dec = 1'b1;
            if (at_one) begin
              state_d = DONE;
              exp_d   = 1'b1;
            end
          end
`endif
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_1HZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  assign running = (state_q == RUN);
  assign expired = exp_q;

  cd_field #(.W(W), .MAX(MS_MAX)) u_sec (
    .clk_i      (clock_1HZ),
    .rst_n_i    (reset),
    .load_i     (fld_load),
    .load_val_i (ld_s),
    .dec_en_i   (dec),
    .val_o      (second),
    .is_zero_o  (s_zero),
    .borrow_o   (s_borrow)
  );

  cd_field #(.W(W), .MAX(MS_MAX)) u_min (
    .clk_i      (clock_1HZ),
    .rst_n_i    (reset),
    .load_i     (fld_load),
    .load_val_i (ld_m),
    .dec_en_i   (s_borrow),
    .val_o      (minute),
    .is_zero_o  (m_zero),
    .borrow_o   (m_borrow)
  );

  cd_field #(.W(W), .MAX(HOUR_MAX)) u_hour (
    .clk_i      (clock_1HZ),
    .rst_n_i    (reset),
    .load_i     (fld_load),
    .load_val_i (ld_h),
    .dec_en_i   (m_borrow),
    .val_o      (hour),
    .is_zero_o  (h_zero),
    .borrow_o   (h_borrow_unused)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer.
// Reference model keeps remaining time as a plain count of seconds.
module tb_countdown_timer;

  logic       clock_1HZ = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pre_h = '0;
  logic [7:0] pre_m = '0;
  logic [7:0] pre_s = '0;
  logic [7:0] hour, minute, second;
  logic       running, expired;

  int n_cmp = 0;
  int n_err = 0;

  int rem = 0;
  bit m_cnt = 0;
  bit m_done = 0;
  bit m_exp = 0;

  countdown_timer dut (
    .clock_1HZ (clock_1HZ),
    .reset     (reset),
    .load      (load),
    .run       (run),
    .pre_h     (pre_h),
    .pre_m     (pre_m),
    .pre_s     (pre_s),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .running   (running),
    .expired   (expired)
  );

  always #5 clock_1HZ = ~clock_1HZ;

  function automatic int cl(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".h"}, int'(hour),   rem / 3600);
    chk({tag, ".m"}, int'(minute), (rem / 60) % 60);
    chk({tag, ".s"}, int'(second), rem % 60);
    chk({tag, ".run"}, int'(running), int'(m_cnt));
    chk({tag, ".exp"}, int'(expired), int'(m_exp));
  endtask

  task automatic model_edge();
    if (load) begin
      rem = cl(pre_h, 23) * 3600 + cl(pre_m, 59) * 60 + cl(pre_s, 59);
      m_cnt = 0; m_done = 0; m_exp = 0;
    end else if (m_done) begin
    end else if (m_cnt) begin
      if (!run) m_cnt = 0;
      else begin
        rem--;
        if (rem == 0) begin m_cnt = 0; m_done = 1; m_exp = 1; end
      end
    end else if (run) begin
      if (rem == 0) begin m_done = 1; m_exp = 1; end
      else m_cnt = 1;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock_1HZ);
    #1;
    chk_all(tag);
  endtask

  task automatic set_pre(input int h, input int m, input int s);
    pre_h = 8'(h); pre_m = 8'(m); pre_s = 8'(s);
  endtask

  initial begin
    #12;
    chk_all("reset");
    reset = 1'b1;
    @(negedge clock_1HZ);

`ifdef COUNTDOWN_REPEAT_EN
    set_pre(0, 0, 2); load = 1;
    @(posedge clock_1HZ); #1;
    load = 0; run = 1;
    @(posedge clock_1HZ); #1;
    chk("r.arm", int'(second), 2);
    @(posedge clock_1HZ); #1;
    chk("r.s1", int'(second), 1);
    chk("r.e1", int'(expired), 0);
    @(posedge clock_1HZ); #1;
    chk("r.s0", int'(second), 0);
    chk("r.e0", int'(expired), 1);
    chk("r.run0", int'(running), 1);
    @(posedge clock_1HZ); #1;
    chk("r.s2", int'(second), 2);
    chk("r.e2", int'(expired), 0);
    @(posedge clock_1HZ); #1;
    chk("r.s1b", int'(second), 1);
    chk("r.run1", int'(running), 1);
`else
    // 1: 00:01:00 runs out after 61 edges
    set_pre(0, 1, 0); load = 1;
    step("t1.load");
    load = 0; run = 1;
    step("t1.arm");
    step("t1.first");
    chk("t1.s59", int'(second), 59);
    for (int i = 0; i < 59; i++) step("t1.cnt");
    chk("t1.zero", int'(second), 0);
    chk("t1.expired", int'(expired), 1);
    chk("t1.running", int'(running), 0);
    step("t1.hold");

    // 2: double borrow
    run = 0; set_pre(1, 0, 0); load = 1;
    step("t2.load");
    load = 0; run = 1;
    step("t2.arm");
    step("t2.borrow");
    chk("t2.m59", int'(minute), 59);

    // 3: clamp
    run = 0; set_pre(30, 75, 99); load = 1;
    step("t3.load");
    chk("t3.h23", int'(hour), 23);
    load = 0;

    // 4: pause and resume
    set_pre(0, 0, 10); load = 1;
    step("t4.load");
    load = 0; run = 1;
    for (int i = 0; i < 4; i++) step("t4.run");
    chk("t4.s7", int'(second), 7);
    run = 0;
    for (int i = 0; i < 3; i++) step("t4.pause");
    chk("t4.hold7", int'(second), 7);
    run = 1;
    step("t4.rearm");
    step("t4.resume");
    chk("t4.s6", int'(second), 6);

    // 5: async reset between edges, then run without load
    #3;
    reset = 1'b0;
    #1;
    rem = 0; m_cnt = 0; m_done = 0; m_exp = 0;
    chk_all("t5.rst");
    reset = 1'b1;
    step("t5.done");
    chk("t5.expired", int'(expired), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 15) == 0);
      run  = ($urandom_range(0, 7) != 0);
      if (load) begin
        if ($urandom_range(0, 3) == 0)
          set_pre($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255));
        else
          set_pre($urandom_range(0, 1) & $urandom_range(0, 1),
                  $urandom_range(0, 2), $urandom_range(0, 6));
      end
      step("rnd");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
